// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit_pkg
//  Description : Shared CPU definitions for the multiply/divide unit opcodes.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    function automatic logic md_op_is_signed(input md_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit_if
//  Description : Execute-stage to mul/div unit request bus and HI/LO readout.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mul_div_unit_if
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    md_op_t           op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, op, a, b, abort,
        input  in_ready, busy, done, hi, lo
    );

    modport slave (
        input  in_valid, op, a, b, abort,
        output in_ready, busy, done, hi, lo
    );

endinterface
`default_nettype wire

// File: rtl/md_iter_step.sv
`default_nettype none
// ============================================================================
//  Module      : md_iter_step
//  Description : One STEP_BITS iteration of shift-add multiply or restoring
//                divide on a shared 2*WIDTH accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_iter_step
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int STEP_BITS = 1
) (
    input  logic               mode_div,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_out
);

    logic [2*WIDTH-1:0] w_acc;
    logic [WIDTH:0]     w_sum;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
    always_comb begin
        w_acc = acc_in;
        w_sum = '0;
        for (int i = 0; i < STEP_BITS; i++) begin
            if (mode_div) begin
                w_sum = {w_acc[2*WIDTH-1:WIDTH], w_acc[WIDTH-1]};
                if (w_sum >= {1'b0, operand}) begin
                    w_sum = w_sum - {1'b0, operand};
                    w_acc = {w_sum[WIDTH-1:0], w_acc[WIDTH-2:0], 1'b1};
                end else begin
                    w_acc = {w_sum[WIDTH-1:0], w_acc[WIDTH-2:0], 1'b0};
                end
            end else begin
                w_sum = {1'b0, w_acc[2*WIDTH-1:WIDTH]}
                      + (w_acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
                w_acc = {w_sum, w_acc[WIDTH-1:1]};
            end
        end
        acc_out = w_acc;
    end

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int STEP_BITS = 1
) (
    input  wire             clk,
    input  wire             resetn,
    mul_div_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    localparam int c_steps = WIDTH / STEP_BITS;
    localparam int c_cnt_w = $clog2(c_steps + 1);

    md_state_t          r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_operand;
    logic               r_is_div;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_accept;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_accept = bus.in_valid && (r_state == MD_IDLE) && !bus.abort;
    assign w_a_neg  = md_op_is_signed(bus.op) && bus.a[WIDTH-1];
    assign w_b_neg  = md_op_is_signed(bus.op) && bus.b[WIDTH-1];
    assign w_a_abs  = w_a_neg ? -bus.a : bus.a;
    assign w_b_abs  = w_b_neg ? -bus.b : bus.b;

    md_iter_step #(
        .WIDTH     (WIDTH),
        .STEP_BITS (STEP_BITS)
    ) u_step (
        .mode_div (r_is_div),
        .acc_in   (r_acc),
        .operand  (r_operand),
        .acc_out  (w_step)
    );

    assign w_prod = r_neg_lo ? -w_step : w_step;
    assign w_quo  = r_neg_lo ? -w_step[WIDTH-1:0] : w_step[WIDTH-1:0];
    assign w_rem  = r_neg_hi ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= MD_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_is_div  <= 1'b0;
            r_neg_lo  <= 1'b0;
            r_neg_hi  <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MD_IDLE: begin
                    if (w_accept) begin
                        case (bus.op)
                            MD_MTHI: r_hi <= bus.a;
                            MD_MTLO: r_lo <= bus.a;
                            MD_MULT, MD_MULTU: begin
                                r_state   <= MD_RUN;
                                r_cnt     <= c_cnt_w'(c_steps);
                                r_is_div  <= 1'b0;
                                r_acc     <= {{WIDTH{1'b0}}, w_b_abs};
                                r_operand <= w_a_abs;
                                r_neg_lo  <= w_a_neg ^ w_b_neg;
                                r_neg_hi  <= 1'b0;
                            end
                            MD_DIV, MD_DIVU: begin
                                r_state   <= MD_RUN;
                                r_cnt     <= c_cnt_w'(c_steps);
                                r_is_div  <= 1'b1;
                                r_acc     <= {{WIDTH{1'b0}}, w_a_abs};
                                r_operand <= w_b_abs;
                                // Divide by zero keeps the all-ones quotient unsigned.
                                r_neg_lo  <= (w_a_neg ^ w_b_neg) && (bus.b != '0);
                                r_neg_hi  <= w_a_neg;
                            end
                            default: ;
                        endcase
                    end
                end
                MD_RUN: begin
                    if (bus.abort) begin
                        r_state <= MD_IDLE;
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == c_cnt_w'(1)) begin
                            r_state <= MD_DONE;
                            r_done  <= 1'b1;
                            if (r_is_div) begin
                                r_hi <= w_rem;
                                r_lo <= w_quo;
                            end else begin
                                r_hi <= w_prod[2*WIDTH-1:WIDTH];
                                r_lo <= w_prod[WIDTH-1:0];
                            end
                        end
                    end
                end
                MD_DONE: r_state <= MD_IDLE;
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    assign bus.in_ready = (r_state == MD_IDLE);
    assign bus.busy     = (r_state == MD_RUN);
    assign bus.done     = r_done;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;

endmodule
`default_nettype wire
